// File: rtl/findmax_pkg.sv
// rtl/findmax_pkg.sv - shared defaults and FSM state encoding for the max-scan controller
package findmax_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_READ,
    ST_DRAIN,
    ST_FIN
  } state_e;

endpackage

// File: rtl/findmax_addr_counter.sv
// rtl/findmax_addr_counter.sv - next-issue address, issued-read count and strobed-word count
module findmax_addr_counter
  import findmax_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic              issue_i,
  input  logic              strobe_i,
  output logic [ADDR_W-1:0] next_addr_o,
  output logic [ADDR_W:0]   issued_o,
  output logic [ADDR_W:0]   words_o
);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   issued_q, issued_d;
  logic [ADDR_W:0]   words_q, words_d;

  // The address register is exactly ADDR_W wide, so the increment wraps for free.
  always_comb begin
    addr_d   = addr_q;
    issued_d = issued_q;
    words_d  = words_q;
    if (load_i) begin
      addr_d   = base_i;
      issued_d = '0;
      words_d  = '0;
    end else begin
      if (issue_i) begin
        addr_d   = addr_q + 1'b1;
        issued_d = issued_q + 1'b1;
      end
      if (strobe_i) begin
        words_d = words_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      issued_q <= '0;
      words_q  <= '0;
    end else begin
      addr_q   <= addr_d;
      issued_q <= issued_d;
      words_q  <= words_d;
    end
  end

  assign next_addr_o = addr_q;
  assign issued_o    = issued_q;
  assign words_o     = words_q;

endmodule

// File: rtl/findmax_scanner.sv
// rtl/findmax_scanner.sv - sequences memory reads over a window and strobes each word to a max comparator
module findmax_scanner
  import findmax_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              hold,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   n_words,
  output logic              ena,
  output logic [ADDR_W-1:0] addra,
  input  logic [DATA_W-1:0] douta,
  output logic              ActiveDatapath,
  output logic              clr_max,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   words_done
);

  state_e            state_q, state_d;
  logic [ADDR_W:0]   n_words_q;
  logic              ena_q, ena_d;
  logic [ADDR_W-1:0] addra_q, addra_d;
  logic              strobe_q, strobe_d;
  logic              clr_q, clr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              load, issue;
  logic [ADDR_W-1:0] next_addr;
  logic [ADDR_W:0]   issued;

  // Read data goes straight to the comparator; this block only times it.
  logic unused_douta;
  assign unused_douta = ^douta;

  findmax_addr_counter #(.ADDR_W(ADDR_W)) u_cnt (
    .clk         (clk),
    .rst_n       (reset),
    .load_i      (load),
    .base_i      (base_addr),
    .issue_i     (issue),
    .strobe_i    (strobe_d),
    .next_addr_o (next_addr),
    .issued_o    (issued),
    .words_o     (words_done)
  );

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    issue   = 1'b0;
    clr_d   = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d = ST_CLEAR;
          load    = 1'b1;
          clr_d   = 1'b1;
        end
      end
      ST_CLEAR: begin
        if (n_words_q == '0) begin
          state_d = ST_FIN;
          done_d  = 1'b1;
        end else begin
          state_d = ST_READ;
          issue   = 1'b1;
        end
      end
      ST_READ: begin
        if (issued == n_words_q) begin
          state_d = ST_DRAIN;
        end else if (!hold) begin
          issue = 1'b1;
        end
      end
      ST_DRAIN: begin
        state_d = ST_FIN;
        done_d  = 1'b1;
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (abort && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      issue   = 1'b0;
      clr_d   = 1'b0;
      done_d  = 1'b0;
    end
  end

  // Outputs are registered from next-state decode so they align with the state they describe.
  always_comb begin
    ena_d    = issue;
    addra_d  = issue ? next_addr : addra_q;
    strobe_d = ena_q && !abort;
    busy_d   = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      n_words_q <= '0;
      ena_q     <= 1'b0;
      addra_q   <= '0;
      strobe_q  <= 1'b0;
      clr_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      if (load) begin
        n_words_q <= n_words;
      end
      ena_q    <= ena_d;
      addra_q  <= addra_d;
      strobe_q <= strobe_d;
      clr_q    <= clr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign ena            = ena_q;
  assign addra          = addra_q;
  assign ActiveDatapath = strobe_q;
  assign clr_max        = clr_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule

// File: tb/tb_findmax_scanner.sv
// tb/tb_findmax_scanner.sv - table-driven scan vectors with an address scoreboard plus reset/abort sequences
module tb_findmax_scanner;

  localparam int AW = 8;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset, start, abort, hold;
  logic [AW-1:0] base_addr;
  logic [AW:0]   n_words;
  logic          ena;
  logic [AW-1:0] addra;
  logic [DW-1:0] douta;
  logic          ActiveDatapath, clr_max, busy, done;
  logic [AW:0]   words_done;

  int errors = 0;
  int checks = 0;
  logic [AW-1:0] exp_addr_q[$];

  typedef struct {
    logic [AW-1:0] base;
    int n;
    int hold_at;
    int hold_len;
    int abort_ena;
    int restart_at;
    int exp_ena;
    int exp_strb;
    int exp_done;
    int exp_words;
  } vec_t;

  vec_t vecs[9];

  always #5 clk = ~clk;

  assign douta = {8'h00, addra} ^ 16'hA5A5;

  findmax_scanner #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .abort          (abort),
    .hold           (hold),
    .base_addr      (base_addr),
    .n_words        (n_words),
    .ena            (ena),
    .addra          (addra),
    .douta          (douta),
    .ActiveDatapath (ActiveDatapath),
    .clr_max        (clr_max),
    .busy           (busy),
    .done           (done),
    .words_done     (words_done)
  );

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_scan(input vec_t v, input int idx);
    int ena_cnt = 0, strb_cnt = 0, clr_cnt = 0, clr_first = 0;
    int done_cnt = 0, done_cyc = 0, strobe_bad = 0, busy_bad = 0, abort_cyc = 0;
    bit finished = 0;
    logic prev_ena = 1'b0;
    logic exp_busy, exp_strobe;
    logic [AW-1:0] a;
    for (int i = 0; i < v.exp_ena; i++) begin
      a = v.base + AW'(i);
      exp_addr_q.push_back(a);
    end
    base_addr = v.base;
    n_words   = 9'(v.n);
    start     = 1'b1;
    for (int cyc = 1; cyc < 600; cyc++) begin
      next_cycle();
      if (clr_max) begin
        clr_cnt++;
        if (clr_first == 0) clr_first = cyc;
      end
      if (ena) begin
        ena_cnt++;
        if (exp_addr_q.size() > 0)
          check($sformatf("v%0d_addra_c%0d", idx, cyc), addra, exp_addr_q.pop_front());
      end
      exp_strobe = prev_ena && !abort;
      if (ActiveDatapath !== exp_strobe) strobe_bad++;
      if (ActiveDatapath) strb_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      exp_busy = (v.abort_ena == 0) ? (cyc <= v.exp_done) : (abort_cyc == 0 || cyc <= abort_cyc);
      if (busy !== exp_busy) busy_bad++;
      prev_ena = ena;
      start = (cyc == v.restart_at);
      hold  = (v.hold_len > 0 && cyc >= v.hold_at && cyc < v.hold_at + v.hold_len);
      if (v.abort_ena != 0 && abort_cyc == 0 && ena_cnt == v.abort_ena) begin
        abort     = 1'b1;
        abort_cyc = cyc;
      end else begin
        abort = 1'b0;
      end
      if ((v.abort_ena == 0 && cyc >= v.exp_done + 2) || (abort_cyc != 0 && cyc >= abort_cyc + 3)) begin
        finished = 1;
        break;
      end
    end
    start = 1'b0; hold = 1'b0; abort = 1'b0;
    check($sformatf("v%0d_finished_in_budget", idx), finished, 1);
    check($sformatf("v%0d_clr_cycle", idx), clr_first, 1);
    check($sformatf("v%0d_clr_count", idx), clr_cnt, 1);
    check($sformatf("v%0d_ena_count", idx), ena_cnt, v.exp_ena);
    check($sformatf("v%0d_strobe_count", idx), strb_cnt, v.exp_strb);
    check($sformatf("v%0d_strobe_timing_errs", idx), strobe_bad, 0);
    check($sformatf("v%0d_done_cycle", idx), done_cyc, v.exp_done);
    check($sformatf("v%0d_done_count", idx), done_cnt, (v.exp_done != 0) ? 1 : 0);
    check($sformatf("v%0d_words_done", idx), words_done, v.exp_words);
    check($sformatf("v%0d_busy_errs", idx), busy_bad, 0);
    check($sformatf("v%0d_scoreboard_left", idx), exp_addr_q.size(), 0);
    exp_addr_q.delete();
  endtask

  initial begin
    int bad;
    //          base   n    hold_at len abort restart ena  strb done words
    vecs[0] = '{8'h10, 4,   0, 0, 0, 3, 4,   4,   7,   4};
    vecs[1] = '{8'hFE, 4,   0, 0, 0, 0, 4,   4,   7,   4};
    vecs[2] = '{8'h00, 3,   2, 2, 0, 0, 3,   3,   8,   3};
    vecs[3] = '{8'h00, 8,   0, 0, 3, 0, 3,   2,   0,   2};
    vecs[4] = '{8'h55, 0,   0, 0, 0, 0, 0,   0,   2,   0};
    vecs[5] = '{8'h80, 256, 0, 0, 0, 0, 256, 256, 259, 256};
    vecs[6] = '{8'hFF, 1,   0, 0, 0, 0, 1,   1,   4,   1};
    vecs[7] = '{8'h20, 2,   3, 3, 0, 0, 2,   2,   5,   2};
    vecs[8] = '{8'h40, 2,   1, 1, 0, 0, 2,   2,   5,   2};

    reset = 1'b0; start = 1'b0; abort = 1'b0; hold = 1'b0;
    base_addr = '0; n_words = '0;
    @(negedge clk);
    check("reset_outputs", {ena, ActiveDatapath, clr_max, busy, done, addra, words_done}, 0);
    reset = 1'b1;
    next_cycle();

    for (int i = 0; i < 9; i++) run_scan(vecs[i], i);

    // abort wins over start in IDLE
    start = 1'b1; abort = 1'b1;
    next_cycle();
    start = 1'b0; abort = 1'b0;
    check("abort_start_busy", busy, 0);
    check("abort_start_clr", clr_max, 0);

    // abort during CLEAR
    base_addr = 8'h00; n_words = 9'd5; start = 1'b1;
    next_cycle();
    start = 1'b0;
    check("clr_abort_pre_clr", clr_max, 1);
    abort = 1'b1;
    next_cycle();
    abort = 1'b0;
    check("clr_abort_idle", {busy, ena}, 0);
    bad = 0;
    repeat (6) begin
      next_cycle();
      if (ena || ActiveDatapath || done || busy) bad++;
    end
    check("clr_abort_quiet", bad, 0);

    // reset asserted mid-scan
    base_addr = 8'h00; n_words = 9'd8; start = 1'b1;
    next_cycle();
    start = 1'b0;
    repeat (2) next_cycle();
    check("rst_mid_ena_before", ena, 1);
    #2 reset = 1'b0;
    #1;
    check("rst_mid_async_outputs", {ena, ActiveDatapath, clr_max, busy, done, addra, words_done}, 0);
    @(negedge clk);
    reset = 1'b1;
    bad = 0;
    repeat (12) begin
      next_cycle();
      if (ena || ActiveDatapath || done || busy || clr_max) bad++;
    end
    check("rst_mid_quiet_after", bad, 0);

    run_scan(vecs[0], 9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
